alu_issue_queue: RTL and testbench

//   Upstream issue stage for ALU_model. Buffers {opcode, operand_1, operand_2} requests in a

---
 rtl/alu_issue_queue.sv | 139 +++++++++++++
 tb/tb_alu_issue_queue.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_queue.sv
// Issue queue in front of a combinational ALU: buffers requests in a small FIFO,
// issues them one at a time and returns each captured result through a valid/ready handshake.
module alu_issue_queue #(
  parameter int DATA_W = 4,
  parameter int OP_W   = 3,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   in_opcode,
  input  logic [DATA_W-1:0] in_opnd_1,
  input  logic [DATA_W-1:0] in_opnd_2,
  output logic [OP_W-1:0]   alu_opcode,
  output logic [DATA_W-1:0] alu_opnd_1,
  output logic [DATA_W-1:0] alu_opnd_2,
  input  logic [DATA_W-1:0] alu_result,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic [OP_W-1:0]   res_opcode,
  output logic [ADDR_W:0]   count
);

  localparam int ENT_W = OP_W + 2 * DATA_W;

  typedef enum logic [1:0] {IDLE, EXEC, RESULT} state_t;

  state_t              state_q, state_d;
  logic [ENT_W-1:0]    mem_q [DEPTH];
  logic [ENT_W-1:0]    mem_d [DEPTH];
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic [OP_W-1:0]     alu_opcode_q, alu_opcode_d;
  logic [DATA_W-1:0]   alu_opnd_1_q, alu_opnd_1_d;
  logic [DATA_W-1:0]   alu_opnd_2_q, alu_opnd_2_d;
  logic                res_valid_q, res_valid_d;
  logic [DATA_W-1:0]   res_data_q, res_data_d;
  logic [OP_W-1:0]     res_opcode_q, res_opcode_d;
  logic                push, pop;
  logic [ENT_W-1:0]    head;

  assign in_ready   = (count_q != (ADDR_W+1)'(DEPTH));
  assign alu_opcode = alu_opcode_q;
  assign alu_opnd_1 = alu_opnd_1_q;
  assign alu_opnd_2 = alu_opnd_2_q;
  assign res_valid  = res_valid_q;
  assign res_data   = res_data_q;
  assign res_opcode = res_opcode_q;
  assign count      = count_q;
  assign head       = mem_q[rd_ptr_q];

  always_comb begin
    push = in_valid && in_ready;
    // RESULT always has res_valid set, so res_ready alone completes the handshake
    pop  = (count_q != '0) &&
           ((state_q == IDLE) || ((state_q == RESULT) && res_ready));

    mem_d        = mem_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    state_d      = state_q;
    alu_opcode_d = alu_opcode_q;
    alu_opnd_1_d = alu_opnd_1_q;
    alu_opnd_2_d = alu_opnd_2_q;
    res_valid_d  = res_valid_q;
    res_data_d   = res_data_q;
    res_opcode_d = res_opcode_q;

    if (push) begin
      mem_d[wr_ptr_q] = {in_opcode, in_opnd_1, in_opnd_2};
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d                                   = rd_ptr_q + 1'b1;
      {alu_opcode_d, alu_opnd_1_d, alu_opnd_2_d} = head;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    case (state_q)
      IDLE: begin
        if (pop) state_d = EXEC;
      end
      EXEC: begin
        res_data_d   = alu_result;
        res_opcode_d = alu_opcode_q;
        res_valid_d  = 1'b1;
        state_d      = RESULT;
      end
      RESULT: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = pop ? EXEC : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      alu_opcode_q <= '0;
      alu_opnd_1_q <= '0;
      alu_opnd_2_q <= '0;
      res_valid_q  <= 1'b0;
      res_data_q   <= '0;
      res_opcode_q <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      alu_opcode_q <= alu_opcode_d;
      alu_opnd_1_q <= alu_opnd_1_d;
      alu_opnd_2_q <= alu_opnd_2_d;
      res_valid_q  <= res_valid_d;
      res_data_q   <= res_data_d;
      res_opcode_q <= res_opcode_d;
    end
  end

  // Storage needs no reset: entries are only read after being written
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_alu_issue_queue.sv
// Directed bench for alu_issue_queue with an adder standing in for the ALU.
module tb_alu_issue_queue;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_opcode;
  logic [3:0] in_opnd_1;
  logic [3:0] in_opnd_2;
  logic [2:0] alu_opcode;
  logic [3:0] alu_opnd_1;
  logic [3:0] alu_opnd_2;
  logic [3:0] alu_result;
  logic       res_valid;
  logic       res_ready;
  logic [3:0] res_data;
  logic [2:0] res_opcode;
  logic [2:0] count;

  int total = 0;
  int bad   = 0;

  alu_issue_queue #(.DATA_W(4), .OP_W(3), .DEPTH(4), .ADDR_W(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_opnd_1(in_opnd_1), .in_opnd_2(in_opnd_2),
    .alu_opcode(alu_opcode), .alu_opnd_1(alu_opnd_1), .alu_opnd_2(alu_opnd_2),
    .alu_result(alu_result),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_opcode(res_opcode), .count(count)
  );

  assign alu_result = alu_opnd_1 + alu_opnd_2;

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    in_valid  = v;
    in_opcode = op;
    in_opnd_1 = a;
    in_opnd_2 = b;
  endtask

  logic [2:0] r_op [10] = '{3'd1, 3'd2, 3'd7, 3'd0, 3'd3, 3'd5, 3'd6, 3'd4, 3'd1, 3'd2};
  logic [3:0] r_a  [10] = '{4'd2, 4'd9, 4'd14, 4'd8, 4'd15, 4'd6, 4'd1, 4'd12, 4'd10, 4'd3};
  logic [3:0] r_b  [10] = '{4'd3, 4'd4, 4'd5, 4'd8, 4'd1, 4'd7, 4'd0, 4'd11, 4'd2, 4'd13};

  initial begin
    logic [6:0] sb [$];
    logic [6:0] e;
    int sent;
    int got;
    int saw_zero;

    rst_n = 1'b0;
    res_ready = 1'b0;
    drive(1'b0, 3'd0, 4'd0, 4'd0);
    #12;
    chk("rst_res_valid", 32'(res_valid), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_alu_opnd_1", 32'(alu_opnd_1), 0);
    rst_n = 1'b1;
    tick();

    // Single request latency
    res_ready = 1'b1;
    drive(1'b1, 3'd0, 4'd3, 4'd1);
    tick();
    drive(1'b0, 3'd0, 4'd0, 4'd0);
    chk("lat_count_e0", 32'(count), 1);
    tick();
    chk("lat_alu_opnd_1", 32'(alu_opnd_1), 3);
    chk("lat_alu_opnd_2", 32'(alu_opnd_2), 1);
    chk("lat_res_valid_e1", 32'(res_valid), 0);
    tick();
    chk("lat_res_valid_e2", 32'(res_valid), 1);
    chk("lat_res_data", 32'(res_data), 4);
    chk("lat_res_opcode", 32'(res_opcode), 0);
    tick();
    chk("lat_res_valid_e3", 32'(res_valid), 0);

    // Fill with downstream stalled
    res_ready = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      drive(1'b1, 3'(i), 4'(i), 4'(2 * i));
      if (i == 6) chk("fill_in_ready_6th", 32'(in_ready), 0);
      else        chk("fill_in_ready", 32'(in_ready), 1);
      tick();
    end
    drive(1'b0, 3'd0, 4'd0, 4'd0);
    chk("fill_count", 32'(count), 4);
    chk("fill_in_ready_after", 32'(in_ready), 0);
    chk("fill_res_valid", 32'(res_valid), 1);
    chk("fill_res_data", 32'(res_data), 3);

    // Drain: results 3*k in push order, one every two cycles
    res_ready = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      chk("drain_res_valid", 32'(res_valid), 1);
      chk("drain_res_data", 32'(res_data), 32'((3 * k) % 16));
      chk("drain_res_opcode", 32'(res_opcode), 32'(k));
      tick();
      chk("drain_gap", 32'(res_valid), 0);
      chk("drain_count", 32'(count), 32'((k < 4) ? 4 - k : 0));
      tick();
    end
    chk("drain_idle_valid", 32'(res_valid), 0);
    chk("drain_hold_opnd_1", 32'(alu_opnd_1), 5);
    chk("drain_hold_opnd_2", 32'(alu_opnd_2), 10);
    chk("drain_in_ready", 32'(in_ready), 1);

    // Push and pop on the same edge at count=2
    res_ready = 1'b0;
    drive(1'b1, 3'd2, 4'd1, 4'd1);
    tick();
    drive(1'b1, 3'd3, 4'd2, 4'd2);
    tick();
    drive(1'b1, 3'd4, 4'd5, 4'd5);
    tick();
    chk("pp_count_before", 32'(count), 2);
    chk("pp_res_data_a", 32'(res_data), 2);
    drive(1'b1, 3'd5, 4'd7, 4'd8);
    res_ready = 1'b1;
    tick();
    drive(1'b0, 3'd0, 4'd0, 4'd0);
    chk("pp_count_after", 32'(count), 2);
    tick();
    chk("pp_res_data_b", 32'(res_data), 4);
    chk("pp_res_opcode_b", 32'(res_opcode), 3);
    tick();
    tick();
    chk("pp_res_data_c", 32'(res_data), 10);
    tick();
    tick();
    chk("pp_res_data_d", 32'(res_data), 15);
    chk("pp_res_opcode_d", 32'(res_opcode), 5);
    tick();
    chk("pp_empty", 32'(count), 0);

    // Random-gap stream through wrapping pointers
    sent = 0;
    got = 0;
    saw_zero = 0;
    res_ready = 1'b1;
    for (int cyc = 0; cyc < 300 && got < 10; cyc++) begin
      if (res_valid) begin
        if (sb.size() == 0) begin
          chk("stream_unexpected", 32'(res_valid), 0);
        end else begin
          e = sb.pop_front();
          chk("stream_data", 32'(res_data), 32'(e[3:0]));
          chk("stream_opcode", 32'(res_opcode), 32'(e[6:4]));
          if (res_opcode == 3'd3 && res_data == 4'd0) saw_zero = 1;
        end
        got++;
      end
      if (sent < 10 && $urandom_range(0, 2) != 0)
        drive(1'b1, r_op[sent], r_a[sent], r_b[sent]);
      else
        drive(1'b0, 3'd0, 4'd0, 4'd0);
      if (in_valid && in_ready) begin
        sb.push_back({r_op[sent], 4'(r_a[sent] + r_b[sent])});
        sent++;
      end
      tick();
    end
    drive(1'b0, 3'd0, 4'd0, 4'd0);
    chk("stream_sent", 32'(sent), 10);
    chk("stream_got", 32'(got), 10);
    chk("stream_wrap_zero", 32'(saw_zero), 1);

    // Asynchronous reset while holding a result with two entries queued
    res_ready = 1'b0;
    drive(1'b1, 3'd6, 4'd9, 4'd9);
    tick();
    tick();
    tick();
    drive(1'b0, 3'd0, 4'd0, 4'd0);
    chk("pre_rst_count", 32'(count), 2);
    chk("pre_rst_valid", 32'(res_valid), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_res_valid", 32'(res_valid), 0);
    chk("arst_count", 32'(count), 0);
    chk("arst_in_ready", 32'(in_ready), 1);
    chk("arst_alu_opcode", 32'(alu_opcode), 0);
    chk("arst_alu_opnd_1", 32'(alu_opnd_1), 0);
    chk("arst_alu_opnd_2", 32'(alu_opnd_2), 0);
    chk("arst_res_data", 32'(res_data), 0);
    #1;
    rst_n = 1'b1;
    tick();
    tick();
    tick();
    chk("post_rst_valid", 32'(res_valid), 0);
    chk("post_rst_count", 32'(count), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
